// File: rtl/tod_pkg.sv
// Time-of-day generator shared definitions.
// Holds the ToD word layout (seconds / ns / fractional ns), the ns-per-second
// wrap constant and the adjust handshake state encoding.
package tod_pkg;

  localparam int unsigned NS_PER_SEC = 1_000_000_000;

  localparam int unsigned SEC_W = 48;
  localparam int unsigned NS_W  = 32;
  localparam int unsigned FNS_W = 16;
  localparam int unsigned TOD_W = SEC_W + NS_W + FNS_W;

  // Field offsets inside the 96-bit ToD word.
  localparam int unsigned FNS_LSB = 0;
  localparam int unsigned NS_LSB  = FNS_LSB + FNS_W;
  localparam int unsigned SEC_LSB = NS_LSB + NS_W;

  localparam int unsigned PER_NS_W = 4;
  localparam int unsigned ADJ_W    = 30;

  typedef enum logic {
    ADJ_IDLE  = 1'b0,
    ADJ_APPLY = 1'b1
  } adj_state_e;

endpackage

// File: rtl/tod_ns_add.sv
// Combinational ns/fractional-ns adder for the ToD generator.
// Adds the per-clock period and an optional signed offset to the current
// {ns, fns}, wraps ns into [0, 1e9) and reports the seconds carry/borrow.
// Ports:
//   ns_i, fns_i         current ns and fractional ns
//   inc_ns_i, inc_fns_i period added every clock
//   adj_en_i            apply adj_ns_i this cycle
//   adj_neg_i           1 = subtract the offset, 0 = add it
//   adj_ns_i            offset magnitude in ns (< 1e9)
//   ns_o, fns_o         wrapped result
//   carry_o             -1 / 0 / +1 to be applied to the seconds field
module tod_ns_add
  import tod_pkg::*;
(
  input  logic [NS_W-1:0]     ns_i,
  input  logic [FNS_W-1:0]    fns_i,
  input  logic [PER_NS_W-1:0] inc_ns_i,
  input  logic [FNS_W-1:0]    inc_fns_i,
  input  logic                adj_en_i,
  input  logic                adj_neg_i,
  input  logic [ADJ_W-1:0]    adj_ns_i,
  output logic [NS_W-1:0]     ns_o,
  output logic [FNS_W-1:0]    fns_o,
  output logic signed [1:0]   carry_o
);

  // Enough headroom for ns + period + offset (< 2e9) and for a negative result.
  localparam int unsigned AW = NS_W + 3;
  localparam logic signed [AW-1:0] NS_PER_SEC_S = AW'(NS_PER_SEC);

  logic [FNS_W:0]         fns_sum;
  logic signed [AW-1:0]   ns_sum;
  logic signed [AW-1:0]   adj_mag;
  logic signed [AW-1:0]   adj_term;
  logic signed [AW-1:0]   ns_raw;
  logic signed [AW-1:0]   ns_fix;

  always_comb begin
    fns_sum  = {1'b0, fns_i} + {1'b0, inc_fns_i};
    ns_sum   = $signed(AW'(ns_i)) + $signed(AW'(inc_ns_i)) + $signed(AW'(fns_sum[FNS_W]));
    adj_mag  = $signed(AW'(adj_ns_i));
    adj_term = '0;
    if (adj_en_i) begin
      adj_term = adj_neg_i ? -adj_mag : adj_mag;
    end
    ns_raw = ns_sum + adj_term;

    ns_fix  = ns_raw;
    carry_o = 2'sb00;
    if (ns_raw[AW-1]) begin
      ns_fix  = ns_raw + NS_PER_SEC_S;
      carry_o = 2'sb11;
    end else if (ns_raw >= NS_PER_SEC_S) begin
      ns_fix  = ns_raw - NS_PER_SEC_S;
      carry_o = 2'sb01;
    end

    ns_o  = ns_fix[NS_W-1:0];
    fns_o = fns_sum[FNS_W-1:0];
  end

endmodule

// File: rtl/tod_gen.sv
// Free-running PTP time-of-day generator.
// Every clock the active period {ns, fns} is added to the ToD; software can
// reprogram the period, load an absolute ToD, or step it by a signed offset.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   period_wr            strobe capturing period_ns / period_fns
//   load_valid, load_tod strobe + absolute ToD {sec[48], ns[32], fns[16]}
//   adj_valid/adj_ready  offset handshake; adj_neg selects subtract
//   adj_ns               offset magnitude in ns
//   tod_out              registered ToD, tod_valid once loaded
//   pps                  one-cycle pulse when the seconds field steps up
module tod_gen
  import tod_pkg::*;
#(
  parameter int unsigned DEFAULT_PERIOD_NS  = 4,
  parameter logic [15:0] DEFAULT_PERIOD_FNS = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                period_wr,
  input  logic [PER_NS_W-1:0] period_ns,
  input  logic [FNS_W-1:0]    period_fns,
  input  logic                load_valid,
  input  logic [TOD_W-1:0]    load_tod,
  input  logic                adj_valid,
  output logic                adj_ready,
  input  logic                adj_neg,
  input  logic [ADJ_W-1:0]    adj_ns,
  output logic [TOD_W-1:0]    tod_out,
  output logic                tod_valid,
  output logic                pps
);

  localparam logic [PER_NS_W-1:0] DEF_NS = PER_NS_W'(DEFAULT_PERIOD_NS);

  adj_state_e          state_q, state_d;
  logic [TOD_W-1:0]    tod_q, tod_d;
  logic                tod_valid_q, tod_valid_d;
  logic                pps_q, pps_d;
  logic [PER_NS_W-1:0] per_ns_q, per_ns_d;
  logic [FNS_W-1:0]    per_fns_q, per_fns_d;

  logic                adj_acc;
  logic [SEC_W-1:0]    sec_cur, sec_nxt;
  logic [NS_W-1:0]     ns_nxt;
  logic [FNS_W-1:0]    fns_nxt;
  logic signed [1:0]   carry;

  assign adj_acc = adj_valid && adj_ready;
  assign sec_cur = tod_q[SEC_LSB +: SEC_W];

  tod_ns_add u_ns_add (
    .ns_i      (tod_q[NS_LSB +: NS_W]),
    .fns_i     (tod_q[FNS_LSB +: FNS_W]),
    .inc_ns_i  (per_ns_q),
    .inc_fns_i (per_fns_q),
    .adj_en_i  (adj_acc && !load_valid),
    .adj_neg_i (adj_neg),
    .adj_ns_i  (adj_ns),
    .ns_o      (ns_nxt),
    .fns_o     (fns_nxt),
    .carry_o   (carry)
  );

  // Adjust FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ADJ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Adjust FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ADJ_IDLE:  if (adj_acc) state_d = ADJ_APPLY;
      ADJ_APPLY: state_d = ADJ_IDLE;
      default:   state_d = ADJ_IDLE;
    endcase
  end

  // Adjust FSM: outputs (held low throughout reset)
  always_comb begin
    adj_ready = (state_q == ADJ_IDLE) && !rst;
  end

  // ToD next-state: load wins over increment and any same-cycle offset
  always_comb begin
    per_ns_d  = period_wr ? period_ns  : per_ns_q;
    per_fns_d = period_wr ? period_fns : per_fns_q;

    case (carry)
      2'sb01:  sec_nxt = sec_cur + 48'd1;
      2'sb11:  sec_nxt = sec_cur - 48'd1;
      default: sec_nxt = sec_cur;
    endcase

    tod_d       = {sec_nxt, ns_nxt, fns_nxt};
    pps_d       = (carry == 2'sb01);
    tod_valid_d = tod_valid_q;

    if (load_valid) begin
      tod_d       = load_tod;
      pps_d       = 1'b0;
      tod_valid_d = 1'b1;
    end
  end

  // Registered ToD / period state
  always_ff @(posedge clk) begin
    if (rst) begin
      tod_q       <= '0;
      tod_valid_q <= 1'b0;
      pps_q       <= 1'b0;
      per_ns_q    <= DEF_NS;
      per_fns_q   <= DEFAULT_PERIOD_FNS;
    end else begin
      tod_q       <= tod_d;
      tod_valid_q <= tod_valid_d;
      pps_q       <= pps_d;
      per_ns_q    <= per_ns_d;
      per_fns_q   <= per_fns_d;
    end
  end

  assign tod_out   = tod_q;
  assign tod_valid = tod_valid_q;
  assign pps       = pps_q;

endmodule

// File: tb/tb_tod_gen.sv
// Testbench for tod_gen: directed scenarios followed by random traffic, all
// checked against a model that keeps time as one integer count of 2^-16 ns.
module tb_tod_gen;

  localparam logic [127:0] FNS_PER_NS  = 128'd65536;
  localparam logic [127:0] FNS_PER_SEC = 128'd65536 * 128'd1000000000;
  localparam logic [127:0] TOD_MOD     = FNS_PER_SEC * (128'd1 << 48);

  logic        clk = 1'b0;
  logic        rst;
  logic        period_wr;
  logic [3:0]  period_ns;
  logic [15:0] period_fns;
  logic        load_valid;
  logic [95:0] load_tod;
  logic        adj_valid;
  logic        adj_ready;
  logic        adj_neg;
  logic [29:0] adj_ns;
  logic [95:0] tod_out;
  logic        tod_valid;
  logic        pps;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  logic [127:0] m_total;
  logic         m_valid;
  logic         m_pps;
  logic [3:0]   m_pns;
  logic [15:0]  m_pfns;
  logic         m_apply;

  tod_gen #(
    .DEFAULT_PERIOD_NS  (4),
    .DEFAULT_PERIOD_FNS (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .period_wr  (period_wr),
    .period_ns  (period_ns),
    .period_fns (period_fns),
    .load_valid (load_valid),
    .load_tod   (load_tod),
    .adj_valid  (adj_valid),
    .adj_ready  (adj_ready),
    .adj_neg    (adj_neg),
    .adj_ns     (adj_ns),
    .tod_out    (tod_out),
    .tod_valid  (tod_valid),
    .pps        (pps)
  );

  always #2 clk = ~clk;

  function automatic logic [127:0] to_total(input logic [95:0] t);
    return {80'd0, t[95:48]} * FNS_PER_SEC + {96'd0, t[47:16]} * FNS_PER_NS + {112'd0, t[15:0]};
  endfunction

  function automatic logic [95:0] to_fields(input logic [127:0] tot);
    logic [127:0] s, r, n;
    s = tot / FNS_PER_SEC;
    r = tot % FNS_PER_SEC;
    n = r / FNS_PER_NS;
    return {s[47:0], n[31:0], r[15:0]};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    period_wr  = 1'b0;
    load_valid = 1'b0;
    adj_valid  = 1'b0;
  endtask

  // Advance one clock, advance the model with the inputs that were applied,
  // then compare every output.
  task automatic tick(input string tag);
    logic         acc;
    logic [47:0]  old_sec;
    logic [95:0]  f;
    logic [127:0] adj_f;
    @(posedge clk);
    #1;
    if (rst) begin
      m_total = '0;
      m_valid = 1'b0;
      m_pps   = 1'b0;
      m_pns   = 4'd4;
      m_pfns  = 16'h0000;
      m_apply = 1'b0;
    end else begin
      acc     = adj_valid && !m_apply;
      f       = to_fields(m_total);
      old_sec = f[95:48];
      if (load_valid) begin
        m_total = to_total(load_tod);
        m_valid = 1'b1;
        m_pps   = 1'b0;
      end else begin
        m_total = (m_total + {124'd0, m_pns} * FNS_PER_NS + {112'd0, m_pfns}) % TOD_MOD;
        if (acc) begin
          adj_f   = {98'd0, adj_ns} * FNS_PER_NS;
          m_total = adj_neg ? (m_total + TOD_MOD - adj_f) % TOD_MOD
                            : (m_total + adj_f) % TOD_MOD;
        end
        f     = to_fields(m_total);
        m_pps = (f[95:48] == old_sec + 48'd1);
      end
      m_apply = acc;
      if (period_wr) begin
        m_pns  = period_ns;
        m_pfns = period_fns;
      end
    end
    check({tag, "/tod"},   tod_out, to_fields(m_total));
    check({tag, "/valid"}, {95'd0, tod_valid}, {95'd0, m_valid});
    check({tag, "/pps"},   {95'd0, pps},       {95'd0, m_pps});
    check({tag, "/ready"}, {95'd0, adj_ready}, {95'd0, !rst && !m_apply});
  endtask

  initial begin
    logic [47:0] rs;
    logic [31:0] rn;
    int unsigned r;

    rst = 1'b1; adj_neg = 1'b0; adj_ns = '0; period_ns = '0; period_fns = '0; load_tod = '0;
    idle();
    m_total = '0; m_valid = 1'b0; m_pps = 1'b0; m_pns = 4'd4; m_pfns = '0; m_apply = 1'b0;

    // Reset, then release with the default 4 ns period
    tick("rst0");
    tick("rst1");
    check("rst_tod", tod_out, 96'd0);
    check("rst_ready", {95'd0, adj_ready}, 96'd0);
    rst = 1'b0;
    tick("rel1");
    check("rel_ns1", {64'd0, tod_out[47:16]}, 96'd4);
    tick("rel2");
    check("rel_ns2", {64'd0, tod_out[47:16]}, 96'd8);
    tick("rel3");
    check("rel_ns3", {64'd0, tod_out[47:16]}, 96'd12);
    check("rel_valid", {95'd0, tod_valid}, 96'd0);

    // Load just below a second boundary, then carry into seconds
    load_valid = 1'b1;
    load_tod   = {48'd5, 32'd999_999_996, 16'd0};
    tick("ld");
    check("ld_tod", tod_out, {48'd5, 32'd999_999_996, 16'd0});
    idle();
    tick("ld_inc");
    check("sec_carry", tod_out, {48'd6, 32'd0, 16'd0});
    check("sec_pps", {95'd0, pps}, 96'd1);
    tick("ld_inc2");
    check("pps_one", {95'd0, pps}, 96'd0);

    // 2.5 ns period from ns = 0
    period_wr = 1'b1; period_ns = 4'd2; period_fns = 16'h8000;
    load_valid = 1'b1; load_tod = '0;
    tick("p25_ld");
    idle();
    tick("p25a");
    check("p25a", tod_out[47:0], {32'd2, 16'h8000});
    tick("p25b");
    check("p25b", tod_out[47:0], {32'd5, 16'h0000});
    tick("p25c");
    check("p25c", tod_out[47:0], {32'd7, 16'h8000});
    tick("p25d");
    check("p25d", tod_out[47:0], {32'd10, 16'h0000});

    // Negative adjust borrowing through seconds 0
    period_wr = 1'b1; period_ns = 4'd4; period_fns = 16'h0000;
    load_valid = 1'b1; load_tod = {48'd0, 32'd10, 16'd0};
    tick("nadj_ld");
    idle();
    adj_valid = 1'b1; adj_neg = 1'b1; adj_ns = 30'd20;
    tick("nadj");
    check("nadj_tod", tod_out, {48'hFFFF_FFFF_FFFF, 32'd999_999_994, 16'd0});
    check("nadj_pps", {95'd0, pps}, 96'd0);
    check("nadj_rdy", {95'd0, adj_ready}, 96'd0);
    idle();
    tick("nadj_post");
    check("nadj_rdy2", {95'd0, adj_ready}, 96'd1);

    // Seconds wrap at 2^48
    load_valid = 1'b1; load_tod = {48'hFFFF_FFFF_FFFF, 32'd999_999_996, 16'd0};
    tick("wrap_ld");
    idle();
    tick("wrap");
    check("wrap_tod", tod_out, 96'd0);
    check("wrap_pps", {95'd0, pps}, 96'd1);

    // Load and adjust together: load wins
    load_valid = 1'b1; load_tod = {48'h1234_5678_9ABC, 32'd123_456_789, 16'hBEEF};
    adj_valid = 1'b1; adj_neg = 1'b0; adj_ns = 30'd500;
    tick("ldadj");
    check("ldadj_tod", tod_out, {48'h1234_5678_9ABC, 32'd123_456_789, 16'hBEEF});
    idle();
    tick("ldadj_inc");
    check("ldadj_inc", tod_out, {48'h1234_5678_9ABC, 32'd123_456_793, 16'hBEEF});

    // Reset during the APPLY cycle; non-default period must revert
    adj_valid = 1'b1; adj_neg = 1'b0; adj_ns = 30'd100;
    period_wr = 1'b1; period_ns = 4'd3; period_fns = 16'h0000;
    tick("rap_acc");
    idle();
    rst = 1'b1;
    tick("rap_rst");
    check("rap_tod", tod_out, 96'd0);
    check("rap_rdy", {95'd0, adj_ready}, 96'd0);
    rst = 1'b0;
    tick("rap_rel");
    check("rap_rdy2", {95'd0, adj_ready}, 96'd1);
    check("rap_tod2", tod_out, {48'd0, 32'd4, 16'd0});

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r          = $urandom_range(0, 99);
      rst        = (r == 0);
      load_valid = (r >= 1 && r <= 6);
      rs         = ($urandom_range(0, 1) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
      rn         = ($urandom_range(0, 1) == 0) ? 32'(999_999_999 - $urandom_range(0, 40))
                                                : 32'($urandom_range(0, 999_999_999));
      load_tod   = {rs, rn, 16'($urandom)};
      period_wr  = (r >= 7 && r <= 10);
      period_ns  = 4'($urandom_range(0, 15));
      period_fns = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      adj_valid  = ($urandom_range(0, 2) == 0);
      adj_neg    = 1'($urandom_range(0, 1));
      adj_ns     = 30'($urandom_range(0, 999_999_999));
      tick("rnd");
    end

    idle();
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tod_gen.md
TOD_GEN -- requirements
Module: tod_gen

Interface
REQ-001 SHALL provide parameter DEFAULT_PERIOD_NS, default 4, integer ns added per clk (250 MHz clock).
REQ-002 SHALL provide parameter DEFAULT_PERIOD_FNS, default 16'h0000, fractional ns added per clk (units of 2^-16 ns).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port period_wr  input  1  one-cycle strobe, capture period_ns/period_fns.
REQ-006 SHALL have port period_ns  input  4  new integer ns increment.
REQ-007 SHALL have port period_fns  input  16  new fractional ns increment.
REQ-008 SHALL have port load_valid  input  1  one-cycle strobe, load absolute ToD.
REQ-009 SHALL have port load_tod  input  96  absolute ToD: [95:48] seconds, [47:16] ns (<1e9), [15:0] fractional ns.
REQ-010 SHALL have port adj_valid  input  1  offset request; accepted when adj_valid and adj_ready are both high.
REQ-011 SHALL have port adj_ready  output  1  high when an offset may be accepted.
REQ-012 SHALL have port adj_neg  input  1  1 = subtract offset, 0 = add offset.
REQ-013 SHALL have port adj_ns  input  30  offset magnitude in ns, <1e9.
REQ-014 SHALL have port tod_out  output  96  current ToD, same format as load_tod, for the 10G and 25G tx/rx ToD inputs.
REQ-015 SHALL have port tod_valid  output  1  high once a ToD has been loaded.
REQ-016 SHALL have port pps  output  1  one-cycle pulse on the cycle tod_out seconds field increments.

Function
REQ-017 SHALL add the active period {ns,fns} to tod_out every clk cycle when no load is applied; tod_out is registered with one cycle of latency.
REQ-018 SHALL carry fractional ns overflow into ns, and SHALL wrap ns at 1,000,000,000 with a +1 carry into seconds.
REQ-019 SHALL wrap seconds modulo 2^48, and SHALL assert pps on that wrap as well.
REQ-020 SHALL apply a new period captured by period_wr from the following increment onward; period_ns=0 and period_fns=0 freezes the ToD.
REQ-021 SHALL set tod_out to load_tod one cycle after load_valid, with no period added on that cycle, and SHALL set tod_valid=1.
REQ-022 SHALL give load priority over adjustment; an adjustment accepted in the same cycle as a load SHALL be discarded.
REQ-023 SHALL apply an accepted adjustment in the next cycle as next = tod + period ± adj_ns, together with the normal increment.
REQ-024 SHALL borrow from seconds on a negative adjust that drops ns below 0 (ns += 1e9); seconds 0 SHALL borrow to 2^48-1.
REQ-025 SHALL assert pps on a seconds increment caused by an adjust, and SHALL NOT assert it on a decrement or on a load.
REQ-026 SHALL deassert adj_ready for exactly one cycle after an accepted adjust (states IDLE -> APPLY -> IDLE); adj_ready is high in IDLE.
REQ-027 SHALL hold the result undefined but non-hanging for a load_tod ns field >= 1e9; such values are illegal and are not checked.

Reset
REQ-028 SHALL on rst set tod_out = 96'h0, tod_valid = 0, pps = 0, and the adjust FSM to IDLE.
REQ-029 SHALL on rst set the active period to {DEFAULT_PERIOD_NS, DEFAULT_PERIOD_FNS}.
REQ-030 SHALL drive adj_ready = 0 while rst is high and adj_ready = 1 on the first cycle after rst deasserts.
REQ-031 SHALL abandon a pending adjust when rst asserts mid-operation; the adjust is not applied after reset.
REQ-032 SHALL keep counting from 0 after reset even while tod_valid = 0.

Structure
REQ-033 SHALL place NS_PER_SEC (1e9), the field widths (SEC_W=48, NS_W=32, FNS_W=16) and the ToD field offsets in shared package tod_pkg.
REQ-034 SHALL implement the ns/fns add with 1e9 wrap and signed carry/borrow (-1/0/+1) as one combinational sub-module, tod_ns_add.

Verification
REQ-035 SHALL cover: reset release with default period -> tod_out ns field = 4, 8, 12 on cycles 1, 2, 3; tod_valid = 0.
REQ-036 SHALL cover: load sec=5, ns=999,999,996, fns=0; then increment -> next cycle sec=5, ns=999,999,996; following cycle sec=6, ns=0 with pps=1 for one cycle.
REQ-037 SHALL cover: period 2.5 ns (period_ns=2, period_fns=16'h8000) from ns=0 -> ns reads 2, 5, 7, 10 and fns alternates 8000/0000.
REQ-038 SHALL cover: at sec=0, ns=10, an adjust with adj_neg=1, adj_ns=20 -> next cycle sec=2^48-1, ns=999,999,994 (period 4), pps=0, adj_ready low for one cycle.
REQ-039 SHALL cover: load_valid and adj_valid in the same cycle -> tod_out equals load_tod exactly and the adjust is not applied.
REQ-040 SHALL cover: rst asserted in the APPLY cycle -> tod_out = 0 and adj_ready = 0 during reset, and adj_ready = 1 afterwards.
